// File: rtl/ddr2_fifo_ctrl_if.sv
// DDR2 controller local-side bus between the FIFO controller and the memory
// controller. master = FIFO controller side, slave = memory controller side.
//   local_init_done   calibration complete (slave -> master)
//   local_ready       request/beat accepted (slave -> master)
//   local_address     burst start word address (master -> slave)
//   local_size        burst length in beats (master -> slave)
//   local_burstbegin  first beat/request of a burst (master -> slave)
//   local_write_req   write beat request (master -> slave)
//   local_wdata       write beat data (master -> slave)
//   local_read_req    read burst request (master -> slave)
//   local_rdata       returned read data (slave -> master)
//   local_rdata_valid local_rdata valid this cycle (slave -> master)
interface ddr2_fifo_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 24
);
  logic              local_init_done;
  logic              local_ready;
  logic [ADDR_W-1:0] local_address;
  logic [6:0]        local_size;
  logic              local_burstbegin;
  logic              local_write_req;
  logic [DATA_W-1:0] local_wdata;
  logic              local_read_req;
  logic [DATA_W-1:0] local_rdata;
  logic              local_rdata_valid;

  modport master (
    input  local_init_done,
    input  local_ready,
    input  local_rdata,
    input  local_rdata_valid,
    output local_address,
    output local_size,
    output local_burstbegin,
    output local_write_req,
    output local_wdata,
    output local_read_req
  );

  modport slave (
    output local_init_done,
    output local_ready,
    output local_rdata,
    output local_rdata_valid,
    input  local_address,
    input  local_size,
    input  local_burstbegin,
    input  local_write_req,
    input  local_wdata,
    input  local_read_req
  );
endinterface

// File: rtl/ddr2_fifo_ctrl.sv
// DDR2 FIFO controller: buffers user writes into fixed-length write bursts
// and prefetches read bursts into a read FIFO for one-cycle-latency reads.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   wr_en, wr_data    user write stream (dropped + wr_ovf when full)
//   rd_en, rd_data    user read stream, rd_data registered (rd_udf on empty)
//   ddr2_init_done    registered copy of local_init_done
//   lif               local bus (ddr2_fifo_ctrl_if.master)
// Optional: define DDR2_FIFO_CTRL_STAT_EN to add the saturating
//   wr_burst_cnt / rd_burst_cnt outputs.
module ddr2_fifo_ctrl #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 24,
  parameter int BURST_LEN  = 64,
  parameter int FIFO_DEPTH = 128,
  parameter int MIN_ADDR   = 0,
  parameter int MAX_ADDR   = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              ddr2_init_done,
  output logic              wr_ovf,
  output logic              rd_udf,
`ifdef DDR2_FIFO_CTRL_STAT_EN
  output logic [15:0]       wr_burst_cnt,
  output logic [15:0]       rd_burst_cnt,
`endif
  ddr2_fifo_ctrl_if.master  lif
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BEAT_W = $clog2(BURST_LEN);

  typedef enum logic [1:0] {
    IDLE,
    WR_BURST,
    RD_REQ
  } state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] wmem [FIFO_DEPTH];
  logic [DATA_W-1:0] rmem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wwp, wrp, rwp, rrp;
  logic [CNT_W-1:0]  wcount, rcount, outstanding;
  logic [BEAT_W-1:0] beat_cnt;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic              rd_active;

  logic wpush, wpop, rpush, rpop;
  logic wr_acc, wr_last, rd_acc;
  logic room_ok;

  logic              o_write_req;
  logic              o_read_req;
  logic              o_burstbegin;
  logic [ADDR_W-1:0] o_address;
  logic [DATA_W-1:0] o_wdata;

  function automatic logic [ADDR_W-1:0] next_addr(
    input logic [ADDR_W-1:0] a
  );
    logic [ADDR_W-1:0] n;
    n = a + ADDR_W'(BURST_LEN);
    return (n >= ADDR_W'(MAX_ADDR)) ? ADDR_W'(MIN_ADDR) : n;
  endfunction

  assign wr_acc  = (state == WR_BURST) && lif.local_ready;
  assign wr_last = wr_acc && (beat_cnt == BEAT_W'(BURST_LEN - 1));
  assign rd_acc  = (state == RD_REQ) && lif.local_ready;

  assign wpush = wr_en && (wcount != CNT_W'(FIFO_DEPTH));
  assign wpop  = wr_acc;
  assign rpush = lif.local_rdata_valid;
  assign rpop  = rd_en && (rcount != '0);

  // Count in-flight read beats as occupied so the read FIFO never overflows.
  assign room_ok = ({1'b0, rcount} + {1'b0, outstanding})
                <= (CNT_W+1)'(FIFO_DEPTH - BURST_LEN);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next state; writes win over reads
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (lif.local_init_done) begin
          if (wcount >= CNT_W'(BURST_LEN))
            state_nxt = WR_BURST;
          else if (rd_active && room_ok)
            state_nxt = RD_REQ;
        end
      end
      WR_BURST: if (wr_last) state_nxt = IDLE;
      RD_REQ:   if (lif.local_ready) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    o_write_req  = 1'b0;
    o_read_req   = 1'b0;
    o_burstbegin = 1'b0;
    o_address    = '0;
    o_wdata      = '0;
    unique case (state)
      WR_BURST: begin
        o_write_req  = 1'b1;
        o_burstbegin = (beat_cnt == '0);
        o_address    = wr_addr;
        o_wdata      = wmem[wrp];
      end
      RD_REQ: begin
        o_read_req   = 1'b1;
        o_burstbegin = 1'b1;
        o_address    = rd_addr;
      end
      default: ;
    endcase
  end

  assign lif.local_write_req  = o_write_req;
  assign lif.local_read_req   = o_read_req;
  assign lif.local_burstbegin = o_burstbegin;
  assign lif.local_address    = o_address;
  assign lif.local_wdata      = o_wdata;
  assign lif.local_size       = 7'(BURST_LEN);

  // FIFO storage (contents need no reset)
  always_ff @(posedge clk) begin
    if (wpush) wmem[wwp] <= wr_data;
    if (rpush) rmem[rwp] <= lif.local_rdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wwp    <= '0;
      wrp    <= '0;
      wcount <= '0;
    end else begin
      if (wpush) wwp <= wwp + PTR_W'(1);
      if (wpop)  wrp <= wrp + PTR_W'(1);
      wcount <= wcount + CNT_W'(wpush) - CNT_W'(wpop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rwp    <= '0;
      rrp    <= '0;
      rcount <= '0;
    end else begin
      if (rpush) rwp <= rwp + PTR_W'(1);
      if (rpop)  rrp <= rrp + PTR_W'(1);
      rcount <= rcount + CNT_W'(rpush) - CNT_W'(rpop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= '0;
    end else begin
      outstanding <= outstanding
                   + (rd_acc ? CNT_W'(BURST_LEN) : '0)
                   - CNT_W'(lif.local_rdata_valid);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
      wr_addr  <= ADDR_W'(MIN_ADDR);
      rd_addr  <= ADDR_W'(MIN_ADDR);
    end else begin
      if (wr_acc)
        beat_cnt <= wr_last ? '0 : beat_cnt + BEAT_W'(1);
      if (wr_last) wr_addr <= next_addr(wr_addr);
      if (rd_acc)  rd_addr <= next_addr(rd_addr);
    end
  end

  // User side: registered read data, sticky error flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data        <= '0;
      ddr2_init_done <= 1'b0;
      wr_ovf         <= 1'b0;
      rd_udf         <= 1'b0;
      rd_active      <= 1'b0;
    end else begin
      ddr2_init_done <= lif.local_init_done;
      if (rpop) rd_data <= rmem[rrp];
      if (wr_en && !wpush) wr_ovf <= 1'b1;
      if (rd_en && !rpop)  rd_udf <= 1'b1;
      if (rd_en && ddr2_init_done) rd_active <= 1'b1;
    end
  end

`ifdef DDR2_FIFO_CTRL_STAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_burst_cnt <= '0;
      rd_burst_cnt <= '0;
    end else begin
      if (wr_last && wr_burst_cnt != 16'hFFFF)
        wr_burst_cnt <= wr_burst_cnt + 16'd1;
      if (rd_acc && rd_burst_cnt != 16'hFFFF)
        rd_burst_cnt <= rd_burst_cnt + 16'd1;
    end
  end
`endif

endmodule
